// File: rtl/jtdd_sdram_sched.sv
// Round-robin read scheduler: four ROM slots, each with a one-word cache, share one
// SDRAM read port through a req/ack/rdy handshake. Refresh is allowed only while idle.
module jtdd_sdram_sched #(
  parameter logic [21:0] OFFSET0 = 22'h0,
  parameter logic [21:0] OFFSET1 = 22'h0,
  parameter logic [21:0] OFFSET2 = 22'h0,
  parameter logic [21:0] OFFSET3 = 22'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        slot0_cs,
  input  logic        slot1_cs,
  input  logic        slot2_cs,
  input  logic        slot3_cs,
  input  logic [21:0] slot0_addr,
  input  logic [21:0] slot1_addr,
  input  logic [21:0] slot2_addr,
  input  logic [21:0] slot3_addr,
  output logic [15:0] slot0_dout,
  output logic [15:0] slot1_dout,
  output logic [15:0] slot2_dout,
  output logic [15:0] slot3_dout,
  output logic        slot0_ok,
  output logic        slot1_ok,
  output logic        slot2_ok,
  output logic        slot3_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [31:0] data_read,
  output logic        refresh_en,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cs;
  logic [21:0] addr   [4];
  logic [21:0] offset [4];
  logic [3:0]  valid_reg;
  logic [20:0] tag_reg  [4];
  logic [31:0] data_reg [4];
  logic [3:0]  hit, miss, ok;
  logic [15:0] dout [4];
  logic        any_miss;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  gnt_reg, gnt_next;
  logic [1:0]  rr_reg, rr_next;
  logic [20:0] tag_req_reg, tag_req_next;
  logic        req_next;
  logic [21:0] sdram_addr_next;
  logic        fill;

  assign cs        = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr[0]   = slot0_addr;
  assign addr[1]   = slot1_addr;
  assign addr[2]   = slot2_addr;
  assign addr[3]   = slot3_addr;
  assign offset[0] = OFFSET0;
  assign offset[1] = OFFSET1;
  assign offset[2] = OFFSET2;
  assign offset[3] = OFFSET3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign hit[gi]  = valid_reg[gi] && (tag_reg[gi] == addr[gi][21:1]);
      assign miss[gi] = cs[gi] && !hit[gi];
      assign ok[gi]   = cs[gi] && hit[gi];
      assign dout[gi] = addr[gi][0] ? data_reg[gi][31:16] : data_reg[gi][15:0];
    end
  endgenerate

  assign any_miss   = |miss;
  assign slot0_ok   = ok[0];
  assign slot1_ok   = ok[1];
  assign slot2_ok   = ok[2];
  assign slot3_ok   = ok[3];
  assign slot0_dout = dout[0];
  assign slot1_dout = dout[1];
  assign slot2_dout = dout[2];
  assign slot3_dout = dout[3];

  // First missing slot at or after the round-robin pointer, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    pick  = rr_reg;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = rr_reg + 2'(k);
      if (!found && miss[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    rr_next         = rr_reg;
    tag_req_next    = tag_req_reg;
    req_next        = sdram_req;
    sdram_addr_next = sdram_addr;
    fill            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_miss) begin
          gnt_next        = pick;
          rr_next         = pick + 2'd1;
          tag_req_next    = addr[pick][21:1];
          sdram_addr_next = {addr[pick][21:1], 1'b0} + offset[pick];
          req_next        = 1'b1;
          state_next      = REQ;
        end
      end
      // An rdy arriving with the ack is deliberately not treated as data.
      REQ: begin
        if (sdram_ack) begin
          req_next   = 1'b0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (data_rdy) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || downloading) begin
      state_reg  <= IDLE;
      sdram_req  <= 1'b0;
      valid_reg  <= '0;
      ready      <= 1'b0;
      refresh_en <= 1'b0;
      if (rst) begin
        sdram_addr  <= '0;
        rr_reg      <= '0;
        gnt_reg     <= '0;
        tag_req_reg <= '0;
      end
    end else begin
      state_reg   <= state_next;
      sdram_req   <= req_next;
      sdram_addr  <= sdram_addr_next;
      rr_reg      <= rr_next;
      gnt_reg     <= gnt_next;
      tag_req_reg <= tag_req_next;
      ready       <= 1'b1;
      refresh_en  <= (state_reg == IDLE) && !any_miss;
      if (fill) valid_reg[gnt_reg] <= 1'b1;
    end
  end

  // The fill always uses the tag latched at grant time, not the live slot address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        tag_reg[k]  <= '0;
        data_reg[k] <= '0;
      end
    end else if (fill && !downloading) begin
      tag_reg[gnt_reg]  <= tag_req_reg;
      data_reg[gnt_reg] <= data_read;
    end
  end

endmodule

// File: tb/tb_jtdd_sdram_sched.sv
// Self-checking bench for jtdd_sdram_sched: vector table, hand-written corner cases and
// randomized rounds checked against a transaction-level round-robin/cache model.
module tb_jtdd_sdram_sched;

  localparam logic [21:0] OFF0 = 22'h000000;
  localparam logic [21:0] OFF1 = 22'h000100;
  localparam logic [21:0] OFF2 = 22'h018000;
  localparam logic [21:0] OFF3 = 22'h3FFFF0;

  logic        clk;
  logic        rst;
  logic        downloading;
  logic [3:0]  cs;
  logic [21:0] addr [4];
  logic [15:0] dout [4];
  logic        ok   [4];
  logic [3:0]  okvec;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic        refresh_en;
  logic        ready;

  logic        resp_ack, resp_rdy, man_rdy;
  logic [31:0] resp_data, man_data;
  int          ack_dly, rdy_dly;
  logic        rand_dly;
  int          fill_count;
  logic [21:0] logq [$];

  int n_cmp;
  int n_fail;

  assign okvec     = {ok[3], ok[2], ok[1], ok[0]};
  assign sdram_ack = resp_ack;
  assign data_rdy  = resp_rdy | man_rdy;
  assign data_read = man_rdy ? man_data : resp_data;

  jtdd_sdram_sched #(
    .OFFSET0(OFF0), .OFFSET1(OFF1), .OFFSET2(OFF2), .OFFSET3(OFF3)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot0_cs(cs[0]), .slot1_cs(cs[1]), .slot2_cs(cs[2]), .slot3_cs(cs[3]),
    .slot0_addr(addr[0]), .slot1_addr(addr[1]), .slot2_addr(addr[2]), .slot3_addr(addr[3]),
    .slot0_dout(dout[0]), .slot1_dout(dout[1]), .slot2_dout(dout[2]), .slot3_dout(dout[3]),
    .slot0_ok(ok[0]), .slot1_ok(ok[1]), .slot2_ok(ok[2]), .slot3_ok(ok[3]),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    if (a == 22'h000004) return 32'hBEEF_1234;
    return {~a[15:0] ^ {10'd0, a[21:16]}, a[15:0] ^ 16'h5A3C};
  endfunction

  function automatic logic [21:0] off_of(input int s);
    case (s)
      0: return OFF0;
      1: return OFF1;
      2: return OFF2;
      default: return OFF3;
    endcase
  endfunction

  function automatic logic [21:0] exp_sdram(input int s, input logic [21:0] a);
    return {a[21:1], 1'b0} + off_of(s);
  endfunction

  function automatic logic [15:0] half(input logic [31:0] w, input logic b);
    return b ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [21:0] log_at(input int i);
    if (i < 0 || i >= logq.size()) return 22'h3FFFFF;
    return logq[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_ok(input int s, input int budget);
    int i;
    i = 0;
    while (!ok[s] && i < budget) begin
      step();
      i++;
    end
    chk($sformatf("ok%0d_arrives", s), 32'(ok[s]), 32'd1);
  endtask

  task automatic wait_req(input int budget);
    int i;
    i = 0;
    while (!sdram_req && i < budget) begin
      step();
      i++;
    end
    chk("req_rises", 32'(sdram_req), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cs  = 4'h0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  // SDRAM controller: logs each request, acks and returns data after configurable delays.
  initial begin : responder
    int phase, cnt;
    logic [21:0] cur;
    phase = 0; cnt = 0; cur = '0;
    resp_ack = 1'b0; resp_rdy = 1'b0; resp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      resp_rdy = 1'b0;
      if (rst || downloading) begin
        phase = 0;
      end else begin
        if (phase == 0 && sdram_req) begin
          cur = sdram_addr;
          logq.push_back(cur);
          phase = 1;
          cnt = rand_dly ? int'($urandom_range(0, 3)) : ack_dly;
        end else if (phase == 1) begin
          chk("req_held", {9'd0, sdram_req, sdram_addr}, {9'd0, 1'b1, cur});
        end
        if (phase == 1) begin
          if (cnt == 0) begin
            resp_ack = 1'b1;
            phase = 2;
            cnt = rand_dly ? int'($urandom_range(0, 3)) : rdy_dly;
          end else cnt--;
        end else if (phase == 2) begin
          if (cnt == 0) begin
            resp_rdy  = 1'b1;
            resp_data = mem_word(cur);
            fill_count++;
            phase = 0;
          end else cnt--;
        end
      end
    end
  end

  typedef struct {
    int          slot;
    logic [21:0] a;
    logic [21:0] exp_sdram;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        tbl [5];
  logic        mval [4];
  logic [20:0] mtag [4];

  initial begin : main
    int n0, fc, i, mrr, last;
    logic [21:0] expq [$];
    logic [3:0]  act;

    n_cmp = 0; n_fail = 0;
    rst = 1'b1; downloading = 1'b0; cs = 4'h0;
    for (int s = 0; s < 4; s++) addr[s] = '0;
    man_rdy = 1'b0; man_data = '0;
    ack_dly = 0; rdy_dly = 0; rand_dly = 1'b0; fill_count = 0;

    tbl[0] = '{0, 22'h000004, 22'h000004, 32'hBEEF_1234};
    tbl[1] = '{2, 22'h000010, 22'h018010, mem_word(22'h018010)};
    tbl[2] = '{3, 22'h00001F, 22'h00000E, mem_word(22'h00000E)};
    tbl[3] = '{1, 22'h2AAAAB, 22'h2AABAA, mem_word(22'h2AABAA)};
    tbl[4] = '{0, 22'h3FFFFF, 22'h3FFFFE, mem_word(22'h3FFFFE)};

    // Reset state, with every slot selecting so that ok must be held low by valid.
    cs = 4'hF;
    repeat (3) step();
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_refresh", 32'(refresh_en), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rst_ok%0d", s), 32'(ok[s]), 32'd0);
      chk($sformatf("rst_dout%0d", s), 32'(dout[s]), 32'd0);
    end
    cs = 4'h0;
    rst = 1'b0;
    step();
    chk("ready_up", 32'(ready), 32'd1);
    chk("idle_refresh", 32'(refresh_en), 32'd1);
    chk("no_req_after_rst", 32'(logq.size()), 32'd0);

    // Refresh drops one cycle after a miss and returns after the fill.
    ack_dly = 0; rdy_dly = 0;
    cs = 4'b1000; addr[3] = 22'h000200;
    step();
    chk("miss_refresh_low", 32'(refresh_en), 32'd0);
    chk("miss_req_high", 32'(sdram_req), 32'd1);
    wait_ok(3, 20);
    chk("t6_sdram_addr", 32'(log_at(0)), 32'(exp_sdram(3, 22'h000200)));
    chk("t6_dout", 32'(dout[3]), 32'(half(mem_word(22'h0001F0), 1'b0)));
    step();
    chk("refresh_back", 32'(refresh_en), 32'd1);
    $display("refresh txn: sdram_addr=%h refresh_en=%0d", log_at(0), refresh_en);
    cs = 4'h0;

    // Vector table: miss, fill, then the other half of the word hits with no new request.
    ack_dly = 1; rdy_dly = 0;
    for (int v = 0; v < 5; v++) begin
      int s;
      s = tbl[v].slot;
      n0 = logq.size();
      cs = 4'h0; cs[s] = 1'b1; addr[s] = tbl[v].a;
      settle();
      chk("tbl_miss", 32'(ok[s]), 32'd0);
      wait_ok(s, 20);
      chk("tbl_nreq", 32'(logq.size() - n0), 32'd1);
      chk("tbl_sdram_addr", 32'(log_at(logq.size() - 1)), 32'(tbl[v].exp_sdram));
      chk("tbl_dout", 32'(dout[s]), 32'(half(tbl[v].exp_word, tbl[v].a[0])));
      addr[s][0] = ~addr[s][0];
      settle();
      chk("tbl_other_ok", 32'(ok[s]), 32'd1);
      chk("tbl_other_dout", 32'(dout[s]), 32'(half(tbl[v].exp_word, ~tbl[v].a[0])));
      repeat (3) step();
      chk("tbl_no_new_req", 32'(logq.size() - n0), 32'd1);
      $display("vector %0d: slot %0d addr %h -> sdram %h dout %h", v, s, tbl[v].a,
               log_at(logq.size() - 1), dout[s]);
    end
    cs = 4'h0;

    // Simultaneous misses from rr=0, with slot 1 re-missing after its fill.
    do_reset();
    ack_dly = 1; rdy_dly = 1;
    n0 = logq.size();
    for (int s = 0; s < 4; s++) addr[s] = 22'h001000 + 22'(s * 64);
    cs = 4'hF;
    settle();
    wait_ok(1, 40);
    addr[1] = 22'h002000;
    i = 0;
    while (okvec != 4'hF && i < 80) begin
      step();
      i++;
    end
    chk("rr_all_ok", 32'(okvec), 32'hF);
    repeat (3) step();
    chk("rr_nreq", 32'(logq.size() - n0), 32'd5);
    chk("rr_g0", 32'(log_at(n0)), 32'(exp_sdram(0, 22'h001000)));
    chk("rr_g1", 32'(log_at(n0 + 1)), 32'(exp_sdram(1, 22'h001040)));
    chk("rr_g2", 32'(log_at(n0 + 2)), 32'(exp_sdram(2, 22'h001080)));
    chk("rr_g3", 32'(log_at(n0 + 3)), 32'(exp_sdram(3, 22'h0010C0)));
    chk("rr_g1_again", 32'(log_at(n0 + 4)), 32'(exp_sdram(1, 22'h002000)));
    $display("round-robin txn: %0d grants", logq.size() - n0);

    // Address changes while waiting for data: stale fill, ok stays low, re-request.
    ack_dly = 0; rdy_dly = 3;
    n0 = logq.size();
    fc = fill_count;
    cs = 4'b0001; addr[0] = 22'h000100;
    settle();
    wait_req(20);
    step();
    addr[0] = 22'h000200;
    i = 0;
    while (fill_count == fc && i < 20) begin
      step();
      i++;
    end
    chk("stale_fill_seen", 32'(fill_count - fc), 32'd1);
    step();
    chk("stale_ok_low", 32'(ok[0]), 32'd0);
    wait_ok(0, 30);
    chk("stale_nreq", 32'(logq.size() - n0), 32'd2);
    chk("stale_first", 32'(log_at(n0)), 32'h000100);
    chk("stale_second", 32'(log_at(n0 + 1)), 32'h000200);
    chk("stale_dout", 32'(dout[0]), 32'(half(mem_word(22'h000200), 1'b0)));
    $display("stale txn: %0d requests", logq.size() - n0);
    cs = 4'h0;

    // Randomized rounds against a transaction-level round-robin/cache model.
    do_reset();
    rand_dly = 1'b1;
    mrr = 0;
    for (int s = 0; s < 4; s++) begin
      mval[s] = 1'b0;
      mtag[s] = '0;
    end
    for (int r = 0; r < 40; r++) begin
      act = 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++)
        addr[s] = 22'(32'h40 + $urandom_range(0, 7)) |
                  (($urandom_range(0, 3) == 0) ? 22'h200000 : 22'h0);
      expq.delete();
      last = -1;
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (mrr + k) % 4;
        if (act[s] && !(mval[s] && mtag[s] == addr[s][21:1])) begin
          expq.push_back(exp_sdram(s, addr[s]));
          last = s;
        end
      end
      n0 = logq.size();
      cs = act;
      settle();
      i = 0;
      while ((okvec & act) != act && i < 100) begin
        step();
        i++;
      end
      chk("rnd_all_ok", 32'(okvec & act), 32'(act));
      repeat (4) step();
      chk("rnd_nreq", 32'(logq.size() - n0), 32'(expq.size()));
      for (int k = 0; k < expq.size(); k++)
        chk("rnd_order", 32'(log_at(n0 + k)), 32'(expq[k]));
      for (int s = 0; s < 4; s++) begin
        if (act[s]) begin
          chk("rnd_ok", 32'(ok[s]), 32'd1);
          chk("rnd_dout", 32'(dout[s]), 32'(half(mem_word(exp_sdram(s, addr[s])), addr[s][0])));
          mval[s] = 1'b1;
          mtag[s] = addr[s][21:1];
        end else begin
          chk("rnd_ok_idle", 32'(ok[s]), 32'd0);
        end
      end
      chk("rnd_refresh", 32'(refresh_en), 32'd1);
      if (last >= 0) mrr = (last + 1) % 4;
      $display("random round %0d: cs=%b requests=%0d", r, act, logq.size() - n0);
    end
    rand_dly = 1'b0;

    // Download during REQ clears everything; a stray rdy afterwards fills nothing.
    ack_dly = 0; rdy_dly = 0;
    cs = 4'b0010; addr[1] = 22'h003000;
    settle();
    wait_ok(1, 30);
    ack_dly = 6;
    cs = 4'b0011; addr[0] = 22'h003100;
    settle();
    wait_req(20);
    downloading = 1'b1;
    step();
    chk("dl_req", 32'(sdram_req), 32'd0);
    chk("dl_ready", 32'(ready), 32'd0);
    chk("dl_refresh", 32'(refresh_en), 32'd0);
    chk("dl_ok0", 32'(ok[0]), 32'd0);
    chk("dl_ok1", 32'(ok[1]), 32'd0);
    cs = 4'h0;
    step();
    downloading = 1'b0;
    step();
    chk("dl_ready_back", 32'(ready), 32'd1);
    man_data = mem_word(22'h003100);
    man_rdy = 1'b1;
    step();
    man_rdy = 1'b0;
    step();
    cs = 4'b0011;
    settle();
    chk("stray_ok0", 32'(ok[0]), 32'd0);
    chk("stray_ok1", 32'(ok[1]), 32'd0);
    $display("download txn: ready=%0d ok0=%0d ok1=%0d", ready, ok[0], ok[1]);
    ack_dly = 0;
    wait_ok(0, 40);
    wait_ok(1, 40);
    cs = 4'h0;

    // Reset while waiting for data, then a stray rdy.
    ack_dly = 0; rdy_dly = 6;
    cs = 4'b0001; addr[0] = 22'h004000;
    settle();
    wait_req(20);
    step();
    rst = 1'b1;
    cs = 4'h0;
    step();
    chk("rst2_req", 32'(sdram_req), 32'd0);
    chk("rst2_addr", 32'(sdram_addr), 32'd0);
    chk("rst2_ready", 32'(ready), 32'd0);
    chk("rst2_refresh", 32'(refresh_en), 32'd0);
    rst = 1'b0;
    step();
    man_data = mem_word(22'h004000);
    man_rdy = 1'b1;
    step();
    man_rdy = 1'b0;
    cs = 4'b0001;
    settle();
    chk("rst2_stray_ok0", 32'(ok[0]), 32'd0);
    $display("reset txn: ready=%0d ok0=%0d", ready, ok[0]);
    cs = 4'h0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
